// File: rtl/tr_rst_seq.sv
`default_nettype none
// =============================================================================
// Module   : tr_rst_seq
// Brief    : Reset sequencer for NUM_TR transceiver lanes sharing one fPLL.
//            Holds the fPLL in powerdown, waits for calibration and a stable
//            lock, then releases TX analog, TX digital and per-lane RX resets
//            in order. Any loss of lock, recalibration or lane_en change
//            falls back to the matching earlier step.
// Revision : 1.0 - initial release
// =============================================================================
module tr_rst_seq #(
   parameter int NUM_TR      = 3,
   parameter int PD_CYCLES   = 16,
   parameter int LOCK_STABLE = 64,
   parameter int TX_DLY      = 8,
   parameter int RX_STABLE   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pll_locked,
   input  logic              pll_cal_busy,
   input  logic [NUM_TR-1:0] rx_lockedtodata,
   input  logic [NUM_TR-1:0] lane_en,
   output logic              pll_powerdown,
   output logic [NUM_TR-1:0] tx_analogreset,
   output logic [NUM_TR-1:0] tx_digitalreset,
   output logic [NUM_TR-1:0] rx_analogreset,
   output logic [NUM_TR-1:0] rx_digitalreset,
   output logic [NUM_TR-1:0] tx_rdy,
   output logic [NUM_TR-1:0] rx_rdy,
   output logic [2:0]        state
);

   typedef enum logic [2:0] {
      S_PD   = 3'd0,
      S_CAL  = 3'd1,
      S_LOCK = 3'd2,
      S_TXA  = 3'd3,
      S_TXD  = 3'd4,
      S_RUN  = 3'd5
   } state_t;

   localparam int c_PD_W   = $clog2(PD_CYCLES + 1);
   localparam int c_LOCK_W = $clog2(LOCK_STABLE + 1);
   localparam int c_TX_W   = $clog2(TX_DLY + 1);
   localparam int c_RX_W   = $clog2(RX_STABLE + 1);

   // Terminal values: each phase counter leaves its state on the last count,
   // so it never exceeds its parameter.
   localparam logic [c_PD_W-1:0]   c_PD_LAST   = c_PD_W'(PD_CYCLES - 1);
   localparam logic [c_LOCK_W-1:0] c_LOCK_LAST = c_LOCK_W'(LOCK_STABLE - 1);
   localparam logic [c_TX_W-1:0]   c_TX_LAST   = c_TX_W'(TX_DLY - 1);
   localparam logic [c_RX_W-1:0]   c_RX_MAX    = c_RX_W'(RX_STABLE);

   // Synchronizer stages
   logic              locked_meta_q;
   logic              locked_s;
   logic              cal_busy_meta_q;
   logic              cal_busy_s;
   logic [NUM_TR-1:0] ltd_meta_q;
   logic [NUM_TR-1:0] lockedtodata_s;

   // Sequencer state and counters
   state_t              state_q, state_d;
   logic [c_PD_W-1:0]   pd_cnt_q, pd_cnt_d;
   logic [c_LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
   logic [c_TX_W-1:0]   txa_cnt_q, txa_cnt_d;
   logic [c_RX_W-1:0]   rx_cnt_q [NUM_TR];
   logic [c_RX_W-1:0]   rx_cnt_d [NUM_TR];
   logic [NUM_TR-1:0]   lane_en_q;

   // Output registers
   logic              pll_powerdown_q, pll_powerdown_d;
   logic [NUM_TR-1:0] tx_areset_q, tx_areset_d;
   logic [NUM_TR-1:0] tx_dreset_q, tx_dreset_d;
   logic [NUM_TR-1:0] rx_areset_q, rx_areset_d;
   logic [NUM_TR-1:0] rx_dreset_q, rx_dreset_d;
   logic [NUM_TR-1:0] tx_rdy_q, tx_rdy_d;
   logic [NUM_TR-1:0] rx_rdy_q, rx_rdy_d;

   logic w_tx_phase;
   logic w_run_d;
   logic w_txa_up_d;
   logic w_txd_up_d;

   // Two-flop synchronizers for the asynchronous PLL and CDR status inputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         locked_meta_q   <= 1'b0;
         locked_s        <= 1'b0;
         cal_busy_meta_q <= 1'b0;
         cal_busy_s      <= 1'b0;
         ltd_meta_q      <= '0;
         lockedtodata_s  <= '0;
      end else begin
         locked_meta_q   <= pll_locked;
         locked_s        <= locked_meta_q;
         cal_busy_meta_q <= pll_cal_busy;
         cal_busy_s      <= cal_busy_meta_q;
         ltd_meta_q      <= rx_lockedtodata;
         lockedtodata_s  <= ltd_meta_q;
      end
   end

   // Global state, phase counters, lane counters and lane_en history
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_PD;
         pd_cnt_q   <= '0;
         lock_cnt_q <= '0;
         txa_cnt_q  <= '0;
         rx_cnt_q   <= '{default: '0};
         lane_en_q  <= '0;
      end else begin
         state_q    <= state_d;
         pd_cnt_q   <= pd_cnt_d;
         lock_cnt_q <= lock_cnt_d;
         txa_cnt_q  <= txa_cnt_d;
         rx_cnt_q   <= rx_cnt_d;
         lane_en_q  <= lane_en;
      end
   end

   // Next-state logic; counters default to zero so every state entry clears them
   always_comb begin
      state_d    = state_q;
      pd_cnt_d   = '0;
      lock_cnt_d = '0;
      txa_cnt_d  = '0;
      w_tx_phase = (state_q == S_TXA) || (state_q == S_TXD) || (state_q == S_RUN);

      case (state_q)
         S_PD: begin
            if (pd_cnt_q == c_PD_LAST) state_d = S_CAL;
            else                       pd_cnt_d = pd_cnt_q + 1'b1;
         end
         S_CAL: begin
            if (!cal_busy_s) state_d = S_LOCK;
         end
         S_LOCK: begin
            if (cal_busy_s) begin
               state_d = S_CAL;
            end else if (locked_s) begin
               if (lock_cnt_q == c_LOCK_LAST) state_d = S_TXA;
               else                           lock_cnt_d = lock_cnt_q + 1'b1;
            end
         end
         S_TXA: begin
            if (txa_cnt_q == c_TX_LAST) state_d = S_TXD;
            else                        txa_cnt_d = txa_cnt_q + 1'b1;
         end
         S_TXD:   state_d = S_RUN;
         S_RUN:   state_d = S_RUN;
         default: state_d = S_PD;
      endcase

      // Fall-back paths once TX release has started; recalibration wins over
      // lock loss, which wins over a lane_en change.
      if (w_tx_phase) begin
         if (cal_busy_s) begin
            state_d   = S_CAL;
            txa_cnt_d = '0;
         end else if (!locked_s) begin
            state_d   = S_LOCK;
            txa_cnt_d = '0;
         end else if (lane_en != lane_en_q) begin
            state_d   = S_TXA;
            txa_cnt_d = '0;
         end
      end
   end

   // Output values for the upcoming state, so outputs change on the same edge as state
   always_comb begin
      pll_powerdown_d = (state_d == S_PD);
      w_run_d         = (state_d == S_RUN);
      w_txa_up_d      = (state_d == S_TXA) || (state_d == S_TXD) || w_run_d;
      w_txd_up_d      = (state_d == S_TXD) || w_run_d;
      tx_areset_d     = '1;
      tx_dreset_d     = '1;
      rx_areset_d     = '1;
      rx_dreset_d     = '1;
      tx_rdy_d        = '0;
      rx_rdy_d        = '0;
      for (int i = 0; i < NUM_TR; i++) begin
         // A lane counts only while staying in S_RUN with its CDR locked
         rx_cnt_d[i] = '0;
         if ((state_q == S_RUN) && w_run_d && lockedtodata_s[i]) begin
            rx_cnt_d[i] = (rx_cnt_q[i] == c_RX_MAX) ? rx_cnt_q[i] : rx_cnt_q[i] + 1'b1;
         end
         tx_areset_d[i] = ~(lane_en[i] & w_txa_up_d);
         tx_dreset_d[i] = ~(lane_en[i] & w_txd_up_d);
         rx_areset_d[i] = ~(lane_en[i] & w_run_d);
         tx_rdy_d[i]    = lane_en[i] & w_run_d;
         rx_rdy_d[i]    = lane_en[i] & w_run_d & (rx_cnt_d[i] == c_RX_MAX);
         rx_dreset_d[i] = ~rx_rdy_d[i];
      end
   end

   // Registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pll_powerdown_q <= 1'b1;
         tx_areset_q     <= '1;
         tx_dreset_q     <= '1;
         rx_areset_q     <= '1;
         rx_dreset_q     <= '1;
         tx_rdy_q        <= '0;
         rx_rdy_q        <= '0;
      end else begin
         pll_powerdown_q <= pll_powerdown_d;
         tx_areset_q     <= tx_areset_d;
         tx_dreset_q     <= tx_dreset_d;
         rx_areset_q     <= rx_areset_d;
         rx_dreset_q     <= rx_dreset_d;
         tx_rdy_q        <= tx_rdy_d;
         rx_rdy_q        <= rx_rdy_d;
      end
   end

   assign pll_powerdown   = pll_powerdown_q;
   assign tx_analogreset  = tx_areset_q;
   assign tx_digitalreset = tx_dreset_q;
   assign rx_analogreset  = rx_areset_q;
   assign rx_digitalreset = rx_dreset_q;
   assign tx_rdy          = tx_rdy_q;
   assign rx_rdy          = rx_rdy_q;
   assign state           = state_q;

endmodule
`default_nettype wire

// File: tb/tb_tr_rst_seq.sv
`default_nettype none
// =============================================================================
// Module   : tb_tr_rst_seq
// Brief    : Directed self-checking bench for tr_rst_seq with default
//            parameters (3 lanes, PD 16, lock 64, TX delay 8, RX stable 32).
// Revision : 1.0 - initial release
// =============================================================================
module tb_tr_rst_seq;

   localparam logic [2:0] S_PD   = 3'd0;
   localparam logic [2:0] S_CAL  = 3'd1;
   localparam logic [2:0] S_LOCK = 3'd2;
   localparam logic [2:0] S_TXA  = 3'd3;
   localparam logic [2:0] S_TXD  = 3'd4;
   localparam logic [2:0] S_RUN  = 3'd5;

   // Lane vector order: tx_analog, tx_digital, rx_analog, rx_digital, tx_rdy, rx_rdy
   localparam logic [17:0] ALL_RST = {3'b111, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000};

   logic       clk = 1'b0;
   logic       rst;
   logic       pll_locked;
   logic       pll_cal_busy;
   logic [2:0] rx_lockedtodata;
   logic [2:0] lane_en;
   logic       pll_powerdown;
   logic [2:0] tx_analogreset;
   logic [2:0] tx_digitalreset;
   logic [2:0] rx_analogreset;
   logic [2:0] rx_digitalreset;
   logic [2:0] tx_rdy;
   logic [2:0] rx_rdy;
   logic [2:0] state;

   logic [21:0] obs;
   logic [21:0] exp_v;
   int          checks = 0;
   int          errors = 0;

   assign obs = {state, pll_powerdown, tx_analogreset, tx_digitalreset,
                 rx_analogreset, rx_digitalreset, tx_rdy, rx_rdy};

   tr_rst_seq dut (
      .clk             (clk),
      .rst             (rst),
      .pll_locked      (pll_locked),
      .pll_cal_busy    (pll_cal_busy),
      .rx_lockedtodata (rx_lockedtodata),
      .lane_en         (lane_en),
      .pll_powerdown   (pll_powerdown),
      .tx_analogreset  (tx_analogreset),
      .tx_digitalreset (tx_digitalreset),
      .rx_analogreset  (rx_analogreset),
      .rx_digitalreset (rx_digitalreset),
      .tx_rdy          (tx_rdy),
      .rx_rdy          (rx_rdy),
      .state           (state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, output int n);
      n = 0;
      while (state !== s && n < budget) begin
         tick(1);
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; pll_locked = 1'b1; pll_cal_busy = 1'b1;
      rx_lockedtodata = 3'b000; lane_en = 3'b111;
      tick(3);
      exp_v = {S_PD, 1'b1, ALL_RST};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL reset_values: got %b expected %b", obs, exp_v); end
      rst = 1'b0;
   endtask

   task automatic test_nominal();
      int n;
      tick(15);
      exp_v = {S_PD, 1'b1, ALL_RST};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL pd_hold: got %b expected %b", obs, exp_v); end
      tick(1);
      exp_v = {S_CAL, 1'b0, ALL_RST};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL pd_to_cal: got %b expected %b", obs, exp_v); end
      tick(5);
      pll_cal_busy = 1'b0;
      tick(2);
      checks++;
      if (state !== S_CAL) begin errors++; $display("FAIL cal_sync_delay: got %0d expected %0d", state, S_CAL); end
      tick(1);
      exp_v = {S_LOCK, 1'b0, ALL_RST};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL cal_to_lock: got %b expected %b", obs, exp_v); end
      wait_state(S_TXA, 200, n);
      checks++;
      if (n !== 64) begin errors++; $display("FAIL lock_cycles: got %0d expected %0d", n, 64); end
      exp_v = {S_TXA, 1'b0, 3'b000, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL txa_outputs: got %b expected %b", obs, exp_v); end
      wait_state(S_TXD, 50, n);
      checks++;
      if (n !== 8) begin errors++; $display("FAIL txa_cycles: got %0d expected %0d", n, 8); end
      exp_v = {S_TXD, 1'b0, 3'b000, 3'b000, 3'b111, 3'b111, 3'b000, 3'b000};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL txd_outputs: got %b expected %b", obs, exp_v); end
      wait_state(S_RUN, 50, n);
      checks++;
      if (n !== 1) begin errors++; $display("FAIL txd_cycles: got %0d expected %0d", n, 1); end
      exp_v = {S_RUN, 1'b0, 3'b000, 3'b000, 3'b000, 3'b111, 3'b111, 3'b000};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL run_entry: got %b expected %b", obs, exp_v); end
      rx_lockedtodata = 3'b111;
      tick(33);
      checks++;
      if (rx_rdy !== 3'b000) begin errors++; $display("FAIL rx_rdy_early: got %b expected %b", rx_rdy, 3'b000); end
      tick(1);
      exp_v = {S_RUN, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b111, 3'b111};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL rx_ready: got %b expected %b", obs, exp_v); end
   endtask

   task automatic test_cdr_loss();
      rx_lockedtodata = 3'b101;
      tick(2);
      checks++;
      if (rx_rdy !== 3'b111) begin errors++; $display("FAIL cdr_sync_delay: got %b expected %b", rx_rdy, 3'b111); end
      tick(1);
      exp_v = {S_RUN, 1'b0, 3'b000, 3'b000, 3'b000, 3'b010, 3'b111, 3'b101};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL cdr_loss_lane1: got %b expected %b", obs, exp_v); end
      rx_lockedtodata = 3'b111;
      tick(33);
      checks++;
      if (rx_rdy !== 3'b101) begin errors++; $display("FAIL cdr_recover_early: got %b expected %b", rx_rdy, 3'b101); end
      tick(1);
      exp_v = {S_RUN, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b111, 3'b111};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL cdr_recover: got %b expected %b", obs, exp_v); end
   endtask

   task automatic test_pll_loss();
      pll_locked = 1'b0;
      tick(2);
      checks++;
      if (state !== S_RUN) begin errors++; $display("FAIL pll_loss_sync_delay: got %0d expected %0d", state, S_RUN); end
      tick(1);
      exp_v = {S_LOCK, 1'b0, ALL_RST};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL pll_loss: got %b expected %b", obs, exp_v); end
      tick(5);
      checks++;
      if (state !== S_LOCK) begin errors++; $display("FAIL pll_loss_hold: got %0d expected %0d", state, S_LOCK); end
   endtask

   task automatic test_lock_glitch();
      int n;
      pll_locked = 1'b1;
      tick(42);
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      wait_state(S_TXA, 200, n);
      checks++;
      if (n !== 66) begin errors++; $display("FAIL glitch_restart_cycles: got %0d expected %0d", n, 66); end
      wait_state(S_RUN, 50, n);
      checks++;
      if (n !== 9) begin errors++; $display("FAIL resequence_to_run: got %0d expected %0d", n, 9); end
      tick(31);
      checks++;
      if (rx_rdy !== 3'b000) begin errors++; $display("FAIL rx_after_reseq_early: got %b expected %b", rx_rdy, 3'b000); end
      tick(1);
      checks++;
      if (rx_rdy !== 3'b111) begin errors++; $display("FAIL rx_after_reseq: got %b expected %b", rx_rdy, 3'b111); end
   endtask

   task automatic test_simultaneous();
      int n;
      pll_cal_busy = 1'b1;
      pll_locked   = 1'b0;
      tick(3);
      exp_v = {S_CAL, 1'b0, ALL_RST};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL cal_priority: got %b expected %b", obs, exp_v); end
      pll_cal_busy = 1'b0;
      pll_locked   = 1'b1;
      wait_state(S_RUN, 200, n);
      checks++;
      if (n !== 76) begin errors++; $display("FAIL cal_recover_cycles: got %0d expected %0d", n, 76); end
      tick(32);
      checks++;
      if (rx_rdy !== 3'b111) begin errors++; $display("FAIL cal_recover_rx: got %b expected %b", rx_rdy, 3'b111); end
   endtask

   task automatic test_lane_change();
      int n;
      lane_en = 3'b011;
      tick(1);
      exp_v = {S_TXA, 1'b0, 3'b100, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL lane_change_restart: got %b expected %b", obs, exp_v); end
      wait_state(S_RUN, 50, n);
      checks++;
      if (n !== 9) begin errors++; $display("FAIL lane_change_to_run: got %0d expected %0d", n, 9); end
      tick(32);
      exp_v = {S_RUN, 1'b0, 3'b100, 3'b100, 3'b100, 3'b100, 3'b011, 3'b011};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL lane_change_run: got %b expected %b", obs, exp_v); end
   endtask

   task automatic test_lane_subset();
      int n;
      int viol;
      viol = 0;
      #2 rst = 1'b1;
      #1;
      exp_v = {S_PD, 1'b1, ALL_RST};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL async_reset_run: got %b expected %b", obs, exp_v); end
      #2 rst = 1'b0;
      n = 0;
      while (state !== S_TXA && n < 200) begin
         tick(1);
         n++;
         if ({tx_analogreset[2], tx_digitalreset[2], rx_analogreset[2], rx_digitalreset[2], tx_rdy[2], rx_rdy[2]} !== 6'b111100) viol++;
      end
      checks++;
      if (n !== 81) begin errors++; $display("FAIL restart_to_txa: got %0d expected %0d", n, 81); end
      tick(3);
      #2 rst = 1'b1;
      #1;
      exp_v = {S_PD, 1'b1, ALL_RST};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL async_reset_txa: got %b expected %b", obs, exp_v); end
      #2 rst = 1'b0;
      n = 0;
      while (state !== S_RUN && n < 200) begin
         tick(1);
         n++;
         if ({tx_analogreset[2], tx_digitalreset[2], rx_analogreset[2], rx_digitalreset[2], tx_rdy[2], rx_rdy[2]} !== 6'b111100) viol++;
      end
      checks++;
      if (n !== 90) begin errors++; $display("FAIL restart_to_run: got %0d expected %0d", n, 90); end
      for (int k = 0; k < 32; k++) begin
         tick(1);
         if ({tx_analogreset[2], tx_digitalreset[2], rx_analogreset[2], rx_digitalreset[2], tx_rdy[2], rx_rdy[2]} !== 6'b111100) viol++;
      end
      exp_v = {S_RUN, 1'b0, 3'b100, 3'b100, 3'b100, 3'b100, 3'b011, 3'b011};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL subset_run: got %b expected %b", obs, exp_v); end
      checks++;
      if (viol !== 0) begin errors++; $display("FAIL lane2_disabled: got %0d violations expected %0d", viol, 0); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_cdr_loss();
      test_pll_loss();
      test_lock_glitch();
      test_simultaneous();
      test_lane_change();
      test_lane_subset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
